// File: rtl/triumph_prefetch_buffer.sv
// Instruction prefetch buffer: sequential fetch requests, in-order response FIFO, branch flush/drain.
// Optional same-cycle response bypass when TRIUMPH_PREFETCH_BYPASS_EN is defined.
module triumph_prefetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_rdata_o,
    output logic [31:0] fetch_addr_o,
    input  logic        fetch_ready_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i
);
    localparam int unsigned   PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned   CW      = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_req;
    logic [31:0]   r_addr;
    logic [31:0]   r_resp_addr;
    logic [CW-1:0] r_occ;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_discard;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic          r_valid;
    logic [31:0]   r_head_data;
    logic [31:0]   r_head_addr;
    logic [31:0]   r_mem_data [DEPTH];
    logic [31:0]   r_mem_addr [DEPTH];

    logic          w_hs;
    logic          w_rv_fetch;
    logic          w_bypass;
    logic          w_pop;
    logic          w_push;
    logic [31:0]   w_addr_nxt;
    logic [31:0]   w_resp_addr_nxt;
    logic [CW-1:0] w_occ_nxt;
    logic [CW-1:0] w_out_nxt;
    logic [CW-1:0] w_discard_nxt;
    logic [CW-1:0] w_occ_after_pop;
    logic          w_valid_nxt;
    logic [31:0]   w_head_data_nxt;
    logic [31:0]   w_head_addr_nxt;
    logic          w_req_nxt;

    assign w_hs       = r_req & instr_gnt_i;
    // A response arriving together with a branch belongs to the old stream and is dropped.
    assign w_rv_fetch = instr_rvalid_i & (r_state == FETCH) & ~branch_i;
    assign w_pop      = r_valid & fetch_ready_i;

`ifdef TRIUMPH_PREFETCH_BYPASS_EN
    assign w_bypass      = w_rv_fetch & (r_occ == ZERO_C);
    assign w_push        = w_rv_fetch & ~(w_bypass & fetch_ready_i);
    assign fetch_valid_o = r_valid | w_bypass;
    assign fetch_rdata_o = w_bypass ? instr_rdata_i : r_head_data;
    assign fetch_addr_o  = w_bypass ? r_resp_addr : r_head_addr;
`else
    assign w_bypass      = 1'b0;
    assign w_push        = w_rv_fetch;
    assign fetch_valid_o = r_valid;
    assign fetch_rdata_o = r_head_data;
    assign fetch_addr_o  = r_head_addr;
`endif

    assign instr_req_o  = r_req;
    assign instr_addr_o = r_addr;

    // Next-state, address and counter computation
    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_resp_addr_nxt = r_resp_addr;
        w_occ_nxt       = r_occ;
        w_out_nxt       = r_out;
        w_discard_nxt   = r_discard;
        if (branch_i) begin
            w_addr_nxt      = {branch_addr_i[31:2], 2'b00};
            w_resp_addr_nxt = {branch_addr_i[31:2], 2'b00};
            w_occ_nxt       = ZERO_C;
            w_out_nxt       = ZERO_C;
            if (r_state == DRAIN) begin
                w_discard_nxt = r_discard - CW'(instr_rvalid_i);
            end else begin
                w_discard_nxt = r_out + CW'(w_hs) - CW'(instr_rvalid_i);
            end
            if (w_discard_nxt != ZERO_C) begin
                w_state_nxt = DRAIN;
            end else begin
                w_state_nxt = FETCH;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = FETCH;
                end
                FETCH: begin
                    w_occ_nxt = r_occ + CW'(w_push) - CW'(w_pop);
                    w_out_nxt = r_out + CW'(w_hs) - CW'(instr_rvalid_i);
                    if (w_hs) begin
                        w_addr_nxt = r_addr + 32'd4;
                    end else begin
                        w_addr_nxt = r_addr;
                    end
                    if (instr_rvalid_i) begin
                        w_resp_addr_nxt = r_resp_addr + 32'd4;
                    end else begin
                        w_resp_addr_nxt = r_resp_addr;
                    end
                end
                DRAIN: begin
                    w_discard_nxt = r_discard - CW'(instr_rvalid_i);
                    if (w_discard_nxt == ZERO_C) begin
                        w_state_nxt = FETCH;
                    end else begin
                        w_state_nxt = DRAIN;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
        w_req_nxt = (w_state_nxt == FETCH) &&
                    (({1'b0, w_occ_nxt} + {1'b0, w_out_nxt}) < {1'b0, DEPTH_C});
    end

    // Next head entry: the entry behind the popped one, or the incoming word into an empty FIFO
    always_comb begin
        w_occ_after_pop = r_occ - CW'(w_pop);
        w_head_data_nxt = r_head_data;
        w_head_addr_nxt = r_head_addr;
        if (branch_i) begin
            w_valid_nxt = 1'b0;
        end else begin
            w_valid_nxt = (w_occ_nxt != ZERO_C);
            if (w_occ_after_pop != ZERO_C) begin
                w_head_data_nxt = r_mem_data[r_rd_ptr + PW'(w_pop)];
                w_head_addr_nxt = r_mem_addr[r_rd_ptr + PW'(w_pop)];
            end else if (w_push) begin
                w_head_data_nxt = instr_rdata_i;
                w_head_addr_nxt = r_resp_addr;
            end else begin
                w_head_data_nxt = r_head_data;
                w_head_addr_nxt = r_head_addr;
            end
        end
    end

    // FIFO storage
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= instr_rdata_i;
            r_mem_addr[r_wr_ptr] <= r_resp_addr;
        end
    end

    // Control state, counters, pointers and registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_req       <= 1'b0;
            r_addr      <= RESET_PC;
            r_resp_addr <= RESET_PC;
            r_occ       <= ZERO_C;
            r_out       <= ZERO_C;
            r_discard   <= ZERO_C;
            r_rd_ptr    <= {PW{1'b0}};
            r_wr_ptr    <= {PW{1'b0}};
            r_valid     <= 1'b0;
            r_head_data <= 32'd0;
            r_head_addr <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_req       <= w_req_nxt;
            r_addr      <= w_addr_nxt;
            r_resp_addr <= w_resp_addr_nxt;
            r_occ       <= w_occ_nxt;
            r_out       <= w_out_nxt;
            r_discard   <= w_discard_nxt;
            r_valid     <= w_valid_nxt;
            r_head_data <= w_head_data_nxt;
            r_head_addr <= w_head_addr_nxt;
            if (branch_i) begin
                r_rd_ptr <= {PW{1'b0}};
                r_wr_ptr <= {PW{1'b0}};
            end else begin
                r_rd_ptr <= r_rd_ptr + PW'(w_pop);
                r_wr_ptr <= r_wr_ptr + PW'(w_push);
            end
        end
    end

endmodule

// File: tb/tb_triumph_prefetch_buffer.sv
// Directed bench for triumph_prefetch_buffer: in-order memory responder plus hand-computed checks.
module tb_triumph_prefetch_buffer;
    localparam logic [31:0] KEY = 32'h5A5A_0000;

`ifdef TRIUMPH_PREFETCH_BYPASS_EN
    localparam int FIRST_IDX  = 2;
    localparam int N_VALID    = 18;
    localparam logic [31:0] BR_POP_VALID = 32'd0;
`else
    localparam int FIRST_IDX  = 3;
    localparam int N_VALID    = 17;
    localparam logic [31:0] BR_POP_VALID = 32'd1;
`endif

    logic        clk;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        fvalid;
    logic [31:0] frdata;
    logic [31:0] faddr;
    logic        ready;
    logic        branch;
    logic [31:0] baddr;
    logic        rsp_en;

    logic        req2;
    logic [31:0] addr2;
    logic        fv2;
    logic [31:0] fr2;
    logic [31:0] fa2;
    logic        one_s;
    logic        zero_s;
    logic [31:0] zero32_s;

    int n_chk;
    int n_err;
    logic [31:0] q[$];

    triumph_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .instr_req_o(req), .instr_addr_o(addr), .instr_gnt_i(gnt),
        .instr_rvalid_i(rvalid), .instr_rdata_i(rdata),
        .fetch_valid_o(fvalid), .fetch_rdata_o(frdata), .fetch_addr_o(faddr),
        .fetch_ready_i(ready), .branch_i(branch), .branch_addr_i(baddr)
    );

    triumph_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk_i(clk), .rst_i(rst),
        .instr_req_o(req2), .instr_addr_o(addr2), .instr_gnt_i(one_s),
        .instr_rvalid_i(zero_s), .instr_rdata_i(zero32_s),
        .fetch_valid_o(fv2), .fetch_rdata_o(fr2), .fetch_addr_o(fa2),
        .fetch_ready_i(zero_s), .branch_i(zero_s), .branch_addr_i(zero32_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: record grants mid-cycle, answer one cycle later in order
    initial begin
        rvalid = 1'b0;
        rdata  = 32'd0;
        forever begin
            @(negedge clk);
            if (rst) q.delete();
            else if (req && gnt) q.push_back(addr);
            @(posedge clk);
            #2;
            if (!rst && rsp_en && q.size() > 0) begin
                rvalid = 1'b1;
                rdata  = q.pop_front() ^ KEY;
            end else begin
                rvalid = 1'b0;
            end
        end
    end

    initial begin
        logic [31:0] wrap_exp [3];
        logic [31:0] exp_req;
        logic [31:0] exp_fetch;
        int n_hs;
        int n_valid;
        int first_idx;
        int n_drain;
        bit found;

        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;
        one_s = 1'b1; zero_s = 1'b0; zero32_s = 32'd0;
        n_chk = 0; n_err = 0;
        rst = 1'b1; gnt = 1'b0; ready = 1'b0; branch = 1'b0; baddr = 32'd0; rsp_en = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_valid", 32'(fvalid), 32'd0);
        chk("rst_rdata", frdata, 32'd0);
        chk("rst_faddr", faddr, 32'd0);
        chk("rst_addr_wrap", addr2, 32'hFFFF_FFF8);

        // Streaming: gnt always, ready always
        @(posedge clk); #1;
        rst = 1'b0; gnt = 1'b1; ready = 1'b1;
        exp_req = 32'd0; exp_fetch = 32'd0; n_hs = 0; n_valid = 0; first_idx = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req && gnt) begin
                chk("seq_req_addr", addr, exp_req);
                exp_req += 32'd4;
                n_hs++;
            end
            if (fvalid) begin
                if (n_valid == 0) first_idx = i;
                chk("seq_faddr", faddr, exp_fetch);
                chk("seq_rdata", frdata, exp_fetch ^ KEY);
                exp_fetch += 32'd4;
                n_valid++;
            end else if (n_valid != 0) begin
                chk("seq_no_gap", 32'(fvalid), 32'd1);
            end
            if (i >= 1 && i <= 3) begin
                chk("wrap_req", 32'(req2), 32'd1);
                chk("wrap_addr", addr2, wrap_exp[i-1]);
            end
            @(posedge clk); #1;
        end
        chk("seq_n_hs", n_hs, 32'd19);
        chk("seq_n_valid", n_valid, N_VALID);
        chk("seq_first_idx", first_idx, FIRST_IDX);

        // Branch coincident with pop and with a response
        branch = 1'b1; baddr = 32'h0000_2000;
        @(negedge clk);
        chk("brpop_valid_before", 32'(fvalid), BR_POP_VALID);
        @(posedge clk); #1;
        branch = 1'b0;
        @(negedge clk);
        chk("brpop_valid_after", 32'(fvalid), 32'd0);
        chk("brpop_req_drain", 32'(req), 32'd0);
        chk("brpop_addr", addr, 32'h0000_2000);

        // Mid-operation reset, then back-pressure fill
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 32'(fvalid), 32'd0);
        chk("midrst_req", 32'(req), 32'd0);
        chk("midrst_addr", addr, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; gnt = 1'b1; ready = 1'b0;
        n_hs = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (req && gnt) n_hs++;
            @(posedge clk); #1;
        end
        chk("full_n_hs", n_hs, 32'd4);
        chk("full_req", 32'(req), 32'd0);
        chk("full_valid", 32'(fvalid), 32'd1);
        chk("full_head", faddr, 32'd0);
        ready = 1'b1;
        @(negedge clk);
        chk("full_pop_head", frdata, 32'd0 ^ KEY);
        @(posedge clk); #1;
        ready = 1'b0;
        n_hs = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (req && gnt) begin
                n_hs++;
                chk("refill_addr", addr, 32'h0000_0010);
            end
            @(posedge clk); #1;
        end
        chk("refill_n_hs", n_hs, 32'd1);
        chk("refill_head", faddr, 32'd4);

        // Grant stall holds request and address
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; gnt = 1'b0; ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_req", 32'(req), 32'd1);
            chk("stall_addr", addr, 32'd0);
            @(posedge clk); #1;
        end
        gnt = 1'b1;
        @(posedge clk); #1;
        gnt = 1'b0;
        @(negedge clk);
        chk("stall_addr_adv", addr, 32'd4);

        // Branch with two outstanding requests -> drain
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; gnt = 1'b1; ready = 1'b1; rsp_en = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        gnt = 1'b0; branch = 1'b1; baddr = 32'h0000_1002;
        @(posedge clk); #1;
        branch = 1'b0; gnt = 1'b1; rsp_en = 1'b1;
        n_drain = 0; found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            if (req) begin
                found = 1'b1;
                chk("drain_next_addr", addr, 32'h0000_1000);
            end else begin
                n_drain++;
                chk("drain_valid", 32'(fvalid), 32'd0);
            end
            @(posedge clk); #1;
        end
        chk("drain_found", 32'(found), 32'd1);
        chk("drain_cycles", n_drain, 32'd2);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (fvalid) begin
                found = 1'b1;
                chk("drain_first_faddr", faddr, 32'h0000_1000);
                chk("drain_first_rdata", frdata, 32'h0000_1000 ^ KEY);
            end
            @(posedge clk); #1;
        end
        chk("drain_valid_found", 32'(found), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/triumph_prefetch_buffer.md
TRIUMPH_PREFETCH_BUFFER -- requirements
Module: triumph_prefetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries and max in-flight requests (power of two, 2..16).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk_i  input  1  single clock; all state on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 instr_req_o  output  1  fetch request to instruction memory.
REQ-006 instr_addr_o  output  32  word-aligned fetch address, valid while instr_req_o=1.
REQ-007 instr_gnt_i  input  1  memory accepts request this cycle.
REQ-008 instr_rvalid_i  input  1  read data returned, in request order, at least 1 cycle after grant.
REQ-009 instr_rdata_i  input  32  returned instruction word.
REQ-010 fetch_valid_o  output  1  head instruction available to IF stage.
REQ-011 fetch_rdata_o  output  32  head instruction word.
REQ-012 fetch_addr_o  output  32  address of head instruction.
REQ-013 fetch_ready_i  input  1  IF stage consumes head when fetch_valid_o=1.
REQ-014 branch_i  input  1  redirect pulse; flush and restart at branch_addr_i.
REQ-015 branch_addr_i  input  32  redirect target; bits [1:0] forced to 0.

Function
REQ-016 FSM states: IDLE, FETCH, DRAIN; reset enters IDLE, IDLE->FETCH unconditionally next cycle.
REQ-017 FETCH: instr_req_o=1 when occupancy + outstanding < DEPTH; else 0.
REQ-018 Request handshake complete on instr_req_o & instr_gnt_i; then instr_addr_o += 4 (wraps 32'hFFFF_FFFC->0), outstanding += 1.
REQ-019 instr_addr_o held stable while instr_req_o=1 and instr_gnt_i=0.
REQ-020 instr_rvalid_i in FETCH: outstanding -= 1; word and its address pushed to FIFO tail.
REQ-021 Pop on fetch_valid_o & fetch_ready_i; push and pop same cycle legal at any occupancy, including full.
REQ-022 Without bypass, fetch latency rvalid -> fetch_valid_o = 1 cycle.
REQ-023 fetch_valid_o = (occupancy != 0); fetch_rdata_o/fetch_addr_o show head entry, held while fetch_ready_i=0.
REQ-024 branch_i (any state): FIFO cleared same edge, instr_addr_o <= branch_addr_i & ~3, discard count <= outstanding (incl. a grant in that same cycle).
REQ-025 branch_i with nonzero discard count -> DRAIN; else -> FETCH.
REQ-026 DRAIN: instr_req_o=0; each instr_rvalid_i decrements discard count, data dropped; count reaching 0 -> FETCH next cycle.
REQ-027 branch_i in DRAIN: retarget address, keep discard count, stay DRAIN.
REQ-028 branch_i coincident with pop: head is dropped; fetch_valid_o=0 next cycle.
REQ-029 branch_i coincident with rvalid: that response is discarded.
REQ-030 Occupancy overflow and underflow impossible by construction (REQ-017).

Reset
REQ-031 Reset values: instr_req_o=0, instr_addr_o=RESET_PC, fetch_valid_o=0, fetch_rdata_o=0, fetch_addr_o=0, occupancy=0, outstanding=0, discard=0, state IDLE.
REQ-032 Reset asserted mid-operation clears all state immediately; late responses after reset release are not expected; memory is reset concurrently.

Configuration
REQ-033 Macro TRIUMPH_PREFETCH_BYPASS_EN defined: FIFO empty & instr_rvalid_i & FETCH drives fetch_valid_o=1 and fetch_rdata_o/fetch_addr_o from response combinationally; if fetch_ready_i=1 word not stored, else pushed.
REQ-034 Macro undefined: all outputs registered; latency per REQ-022.

Verification
REQ-035 Reset release, gnt=1, rvalid 1 cycle after gnt, ready=1 -> addresses 0,4,8,C..., fetch_addr_o sequence matches, no gaps after fill.
REQ-036 ready=0 with DEPTH=4 -> exactly 4 grants, then instr_req_o=0; ready=1 one cycle -> one new request.
REQ-037 branch_i, target 32'h0000_1002, 2 outstanding -> DRAIN, 2 responses dropped, next request address 32'h0000_1000.
REQ-038 gnt=0 for 5 cycles -> instr_addr_o stable, instr_req_o held 1.
REQ-039 Start at RESET_PC=32'hFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-040 Bypass build, empty FIFO, rvalid with ready=1 -> fetch_valid_o same cycle; non-bypass build -> one cycle later.
